// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting between the
// processor data port and a multi-cycle word-wide main memory.
module data_cache #(
   parameter int INDEX_BITS  = 4,
   parameter int OFFSET_BITS = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   output logic [31:0] cpu_rdata,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int WORDS    = 1 << OFFSET_BITS;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] REFILL = 2'd1;
   localparam logic [1:0] WRITE  = 2'd2;
   localparam logic [1:0] WDONE  = 2'd3;

   localparam logic [OFFSET_BITS-1:0] COUNT_ONE  = 1;
   localparam logic [OFFSET_BITS-1:0] COUNT_LAST = {OFFSET_BITS{1'b1}};

   logic [1:0]             state;
   logic [1:0]             next_state;
   logic [OFFSET_BITS-1:0] count;
   logic [LINES-1:0]       valid;
   logic [TAG_BITS-1:0]    tags  [LINES];
   logic [31:0]            words [LINES*WORDS];

   logic [OFFSET_BITS-1:0]            offset;
   logic [INDEX_BITS-1:0]             index;
   logic [TAG_BITS-1:0]               tag;
   logic [INDEX_BITS+OFFSET_BITS-1:0] word_sel;
   logic [INDEX_BITS+OFFSET_BITS-1:0] refill_sel;
   logic                              hit;
   logic                              refill_word;
   logic                              refill_last;
   logic                              unused_byte_bits;

   assign offset           = cpu_addr[OFFSET_BITS+1:2];
   assign index            = cpu_addr[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
   assign tag              = cpu_addr[31:32-TAG_BITS];
   assign word_sel         = {index, offset};
   assign refill_sel       = {index, count};
   assign hit              = valid[index] && (tags[index] == tag);
   assign refill_word      = (state == REFILL) && mem_ready;
   assign refill_last      = refill_word && (count == COUNT_LAST);
   assign unused_byte_bits = ^cpu_addr[1:0];

   // Tags and data carry no reset; only the valid bits decide what is usable.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (refill_word) begin
            words[refill_sel] <= mem_rdata;
         end else if ((state == IDLE) && cpu_wr && hit) begin
            words[word_sel] <= cpu_wdata;
         end
         if (refill_last) begin
            tags[index] <= tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         valid <= '0;
      end else begin
         state <= next_state;
         if ((state == IDLE) && !cpu_wr && cpu_rd && !hit) begin
            count <= '0;
         end else if (refill_word) begin
            count <= count + COUNT_ONE;
         end
         if (refill_last) begin
            valid[index] <= 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (cpu_wr) begin
               next_state = WRITE;
            end else if (cpu_rd && !hit) begin
               next_state = REFILL;
            end
         end
         REFILL:  if (refill_last) next_state = IDLE;
         WRITE:   if (mem_ready) next_state = WDONE;
         default: next_state = IDLE;
      endcase
   end

   // Memory-side signals depend only on state and the held CPU request, so they
   // stay constant for the whole transaction.
   always_comb begin
      stall     = 1'b0;
      cpu_rdata = 32'd0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      case (state)
         IDLE: begin
            if (cpu_wr) begin
               stall = 1'b1;
            end else if (cpu_rd) begin
               if (hit) begin
                  cpu_rdata = words[word_sel];
               end else begin
                  stall = 1'b1;
               end
            end
         end
         REFILL: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {tag, index, count, 2'b00};
         end
         WRITE: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {cpu_addr[31:2], 2'b00};
            mem_wdata = cpu_wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios followed by random
// loads/stores compared against a line-level reference model.
module tb_data_cache;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [31:0] cpu_rdata;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   data_cache dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rd    (cpu_rd),
      .cpu_wr    (cpu_wr),
      .cpu_rdata (cpu_rdata),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Memory as the responder sees it, and the memory the bench expects.
   logic [31:0] phys_mem [int unsigned];
   logic [31:0] ref_mem  [int unsigned];
   // Reference cache: which 16-byte line each index holds.
   logic        ref_valid [16];
   logic [31:0] ref_line  [16];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hA5C30F1E;
   endfunction

   function automatic logic [31:0] phys_read(input logic [31:0] a);
      if (phys_mem.exists(a)) return phys_mem[a];
      return init_word(a);
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_ref();
      for (int i = 0; i < 16; i++) begin
         ref_valid[i] = 1'b0;
         ref_line[i]  = 32'd0;
      end
   endtask

   // Memory responder: random 0..2 cycle gaps, back-to-back pulses allowed.
   initial begin
      int gap;
      mem_ready = 1'b0;
      mem_rdata = 32'd0;
      gap = 0;
      forever begin
         @(posedge clk);
         #2;
         mem_ready = 1'b0;
         mem_rdata = 32'd0;
         if (mem_req && !reset) begin
            if (gap == 0) begin
               mem_ready = 1'b1;
               if (mem_we) phys_mem[mem_addr] = mem_wdata;
               else        mem_rdata = phys_read(mem_addr);
               gap = $urandom_range(0, 2);
            end else begin
               gap--;
            end
         end else begin
            gap = $urandom_range(0, 1);
         end
      end
   end

   task automatic do_read(input logic [31:0] a, input string tag);
      logic [31:0] w;
      logic [31:0] base;
      int          idx;
      bit          hit;
      int          cnt;
      int          cyc;
      w    = a & ~32'h3;
      base = a & ~32'hF;
      idx  = int'((a >> 4) & 32'hF);
      hit  = ref_valid[idx] && (ref_line[idx] == (a >> 4));
      cpu_addr = a;
      cpu_rd   = 1'b1;
      cpu_wr   = 1'b0;
      @(negedge clk);
      if (hit) begin
         check({tag, " hit stall"}, 32'(stall), 32'd0);
         check({tag, " hit rdata"}, cpu_rdata, ref_read(w));
         check({tag, " hit mem_req"}, 32'(mem_req), 32'd0);
      end else begin
         check({tag, " miss stall"}, 32'(stall), 32'd1);
         check({tag, " miss rdata"}, cpu_rdata, 32'd0);
         cnt = 0;
         cyc = 0;
         while (stall && cyc < 40) begin
            if (mem_ready) begin
               check({tag, " refill addr"}, mem_addr, base + 32'(4 * cnt));
               check({tag, " refill we"}, 32'(mem_we), 32'd0);
               cnt++;
            end
            @(negedge clk);
            cyc++;
         end
         check({tag, " refill words"}, 32'(cnt), 32'd4);
         check({tag, " refill done stall"}, 32'(stall), 32'd0);
         check({tag, " refill rdata"}, cpu_rdata, ref_read(w));
         check({tag, " refill done mem_req"}, 32'(mem_req), 32'd0);
         ref_valid[idx] = 1'b1;
         ref_line[idx]  = a >> 4;
      end
      @(posedge clk);
      #1;
      cpu_rd = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit rd_too,
                           input string tag);
      logic [31:0] w;
      int          writes;
      int          cyc;
      w = a & ~32'h3;
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_wr    = 1'b1;
      cpu_rd    = rd_too;
      @(negedge clk);
      check({tag, " store stall"}, 32'(stall), 32'd1);
      check({tag, " store rdata"}, cpu_rdata, 32'd0);
      writes = 0;
      @(negedge clk);
      cyc = 1;
      while (stall && cyc < 40) begin
         check({tag, " store req"}, {30'd0, mem_req, mem_we}, 32'd3);
         check({tag, " store addr"}, mem_addr, w);
         check({tag, " store wdata"}, mem_wdata, d);
         if (mem_ready) writes++;
         @(negedge clk);
         cyc++;
      end
      check({tag, " store writes"}, 32'(writes), 32'd1);
      check({tag, " wdone stall"}, 32'(stall), 32'd0);
      check({tag, " wdone mem_req"}, 32'(mem_req), 32'd0);
      ref_mem[w] = d;
      @(posedge clk);
      #1;
      cpu_wr = 1'b0;
      cpu_rd = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " stall"}, 32'(stall), 32'd0);
      check({tag, " mem_req"}, {30'd0, mem_req, mem_we}, 32'd0);
      check({tag, " mem_addr"}, mem_addr, 32'd0);
      check({tag, " mem_wdata"}, mem_wdata, 32'd0);
      check({tag, " rdata"}, cpu_rdata, 32'd0);
   endtask

   initial begin
      int cnt;
      int cyc;
      logic [31:0] bases [4];
      bases[0] = 32'h0000_0000;
      bases[1] = 32'h0000_0400;
      bases[2] = 32'h0000_2000;
      bases[3] = 32'h0001_0000;

      reset     = 1'b1;
      cpu_addr  = 32'd0;
      cpu_wdata = 32'd0;
      cpu_rd    = 1'b0;
      cpu_wr    = 1'b0;
      clear_ref();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_quiet("after reset");
      @(posedge clk);
      #1;

      do_read(32'h100, "rd 0x100");
      do_read(32'h104, "rd 0x104");
      do_write(32'h108, 32'hDEADBEEF, 1'b0, "wr 0x108");
      do_read(32'h108, "rd 0x108");
      do_read(32'h500, "rd 0x500");
      do_read(32'h100, "rerd 0x100");
      do_read(32'h500, "rerd 0x500");
      do_write(32'h2000, 32'h12345678, 1'b1, "wr 0x2000");
      do_read(32'h2000, "rd 0x2000");

      // Reset after two of the four refill words of 0x300.
      cpu_addr = 32'h300;
      cpu_rd   = 1'b1;
      @(negedge clk);
      check("rst-refill stall", 32'(stall), 32'd1);
      cnt = 0;
      cyc = 0;
      while (cnt < 2 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (mem_ready) cnt++;
      end
      check("rst-refill words seen", 32'(cnt), 32'd2);
      @(posedge clk);
      #1;
      reset  = 1'b1;
      cpu_rd = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_ref();
      @(negedge clk);
      check_quiet("after mid-refill reset");
      @(posedge clk);
      #1;
      do_read(32'h300, "rerd 0x300");
      do_read(32'h100, "rd 0x100 post-reset");

      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         a = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) < 3) begin
            do_write(a, $urandom, 1'($urandom_range(0, 1)), "rand wr");
         end else begin
            do_read(a, "rand rd");
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the processor datapath's data-memory port (ALU result as address, register-file read data as store data) and a multi-cycle main memory. Read hits return data in the same cycle. Misses and all stores assert `stall` to freeze the processor while the controller refills a line or writes through to memory. The block replaces the direct data-memory connection in the cache-integrated processor.

## Interface
Parameters:
- `INDEX_BITS`, 4: line index width (2^INDEX_BITS lines).
- `OFFSET_BITS`, 2: word-offset width (2^OFFSET_BITS 32-bit words per line).
- Tag width is derived as 32 - INDEX_BITS - OFFSET_BITS - 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_addr`  in  32  byte address from the ALU result; bits [1:0] ignored.
- `cpu_wdata`  in  32  store data.
- `cpu_rd`  in  1  load request, level, held while `stall`=1.
- `cpu_wr`  in  1  store request, level, held while `stall`=1.
- `cpu_rdata`  out  32  load data, combinational; valid when `cpu_rd`=1 and `stall`=0.
- `stall`  out  1  processor freeze; the PC and pipeline hold while it is high.
- `mem_req`  out  1  memory request; held high for a whole transaction.
- `mem_we`  out  1  1 = memory write, 0 = memory read.
- `mem_addr`  out  32  word-aligned memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data; valid when `mem_ready`=1.
- `mem_ready`  in  1  one-cycle pulse per completed word.

## Operation
- Address split: offset = `cpu_addr[OFFSET_BITS+1:2]`, index = next INDEX_BITS bits, tag = remaining upper bits.
- Per-line state: valid bit, tag, and 2^OFFSET_BITS data words. Hit = valid AND tag match.
- FSM states: IDLE, REFILL, WRITE, WDONE.
- IDLE, `cpu_wr`=1 (takes priority when `cpu_rd` is also 1):
  - If the store hits, update the cached word at this edge.
  - Go to WRITE. `stall`=1 combinationally in this cycle.
- IDLE, `cpu_rd`=1 and hit: `cpu_rdata` = cached word, `stall`=0, no memory traffic.
- IDLE, `cpu_rd`=1 and miss: `stall`=1 combinationally. Clear the word counter and go to REFILL.
- REFILL:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr` = {tag, index, counter, 2'b00}.
  - On each `mem_ready`, write `mem_rdata` into the line word selected by the counter, then increment the counter.
  - On the last word: set valid, store the tag, return to IDLE.
  - The held read then hits in IDLE.
- WRITE:
  - Drive `mem_req`=1, `mem_we`=1, `mem_addr` = {`cpu_addr[31:2]`, 2'b00}, `mem_wdata` = `cpu_wdata`.
  - On `mem_ready`, go to WDONE.
- WDONE:
  - `stall`=0 for exactly one cycle while the processor advances past the store.
  - CPU requests are ignored in this cycle, so the store is not repeated.
  - Next state is IDLE.
- Write miss: memory is written, the cache is left unchanged (no allocate).
- Outside REFILL/WRITE: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. `mem_ready` is ignored.
- `cpu_rdata` = 0 whenever the current access is not a read hit in IDLE.

## Timing
- Reset, applied on any edge:
  - State = IDLE, counter = 0, all valid bits = 0. Tags and data are left unchanged.
  - Outputs the cycle after reset: `stall`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rdata`=0.
- Reset mid-REFILL: the transaction is abandoned and the line stays invalid. `mem_req` is 0 in the next cycle.
- Read hit latency: 0 cycles.
- Read miss: `stall` is high from the request cycle through the cycle of the last `mem_ready`. The data is returned in the following IDLE cycle. Total latency = 2^OFFSET_BITS memory words + 1 cycle.
- Store: `stall` is high from the request cycle through the `mem_ready` cycle. `stall` drops in WDONE.
- Counter wraps to 0 after the last word; `mem_addr` never leaves the line.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable for the whole transaction.
- `mem_ready` may arrive as early as the first cycle of REFILL/WRITE. Back-to-back `mem_ready` pulses are legal.

## Test plan
- Reset, then read 0x100. Required: `stall` high and memory reads at 0x100, 0x104, 0x108, 0x10C. After the refill, `stall`=0 and `cpu_rdata` = mem[0x100].
- Read 0x104 after that refill. Required: hit, `stall`=0 in the same cycle, `cpu_rdata` = mem[0x104], `mem_req` stays 0.
- Store 0xDEADBEEF to 0x108 (hit). Required:
  - `mem_req`=`mem_we`=1 with `mem_addr`=0x108 until `mem_ready`.
  - One WDONE cycle with `stall`=0 and no second write.
  - A following read of 0x108 returns 0xDEADBEEF with no memory traffic.
- Conflict at defaults: read 0x500 (same index as 0x100). Required: miss and refill of 0x500..0x50C. A re-read of 0x100 misses again.
- Store to 0x2000 (miss). Required: one memory write and no cache change. A following read of 0x2000 misses and refills.
- Reset asserted after 2 of 4 refill words for 0x300. Required: `mem_req`=0 next cycle, `stall`=0. A re-read of 0x300 misses and restarts at 0x300.
